// File: rtl/memctrl_pkg.sv
// rtl/memctrl_pkg.sv - shared BIST state encoding and 16-bit LFSR definition
package memctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RESEED,
    ST_READ,
    ST_DRAIN,
    ST_FIN
  } bist_state_e;

  localparam logic [15:0] LFSR_SEED = 16'h8000;
  // feedback taps at bits 15, 13, 12 and 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr16_step(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_bist_sequencer_if.sv
// rtl/lfsr_bist_sequencer_if.sv - single-port SRAM bus between BIST sequencer and memory
interface lfsr_bist_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              MEM_CS;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;

  modport master (
    output MEM_CS,
    output MEM_WE,
    output MEM_ADDR,
    output MEM_WDATA,
    input  MEM_RDATA
  );

  modport slave (
    input  MEM_CS,
    input  MEM_WE,
    input  MEM_ADDR,
    input  MEM_WDATA,
    output MEM_RDATA
  );
endinterface

// File: rtl/lfsr16_gen.sv
// rtl/lfsr16_gen.sv - 16-bit Fibonacci LFSR with load (priority) and step
module lfsr16_gen
  import memctrl_pkg::*;
#(
  parameter logic [15:0] INIT = LFSR_SEED
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LOAD,
  input  logic        STEP,
  input  logic [15:0] SEED_IN,
  output logic [15:0] OUT
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT <= INIT;
    end else if (LOAD) begin
      OUT <= SEED_IN;
    end else if (STEP) begin
      OUT <= lfsr16_step(OUT);
    end
  end

endmodule

// File: rtl/lfsr_bist_sequencer.sv
// rtl/lfsr_bist_sequencer.sv - LFSR write/read-compare memory BIST sequencer
module lfsr_bist_sequencer
  import memctrl_pkg::*;
#(
  parameter int          ADDR_W = 4,
  parameter int          DATA_W = 16,
  parameter logic [15:0] SEED   = LFSR_SEED
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [ADDR_W:0]      FAIL_CNT,
  output logic [ADDR_W-1:0]    FIRST_FAIL_ADDR,
  lfsr_bist_sequencer_if.master mem
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cmp_addr_q;
  logic [DATA_W-1:0] exp_q;
  logic              cmp_v_q;
  logic [15:0]       lfsr_out;
  logic              lfsr_load, lfsr_step;
  logic              mem_cs, mem_we;
  logic              abort_hit;
  logic              miscmp;

  lfsr16_gen #(.INIT(SEED)) u_lfsr (
    .CLK     (CLK),
    .RST     (RST),
    .LOAD    (lfsr_load),
    .STEP    (lfsr_step),
    .SEED_IN (SEED),
    .OUT     (lfsr_out)
  );

  assign abort_hit = ABORT && (state_q != ST_IDLE);
  assign miscmp    = cmp_v_q && (mem.MEM_RDATA != exp_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START && !ABORT) begin
          state_d   = ST_WRITE;
          lfsr_load = 1'b1;
        end
      end
      ST_WRITE: begin
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        lfsr_step = 1'b1;
        if (&addr_q) state_d = ST_RESEED;
      end
      ST_RESEED: begin
        lfsr_load = 1'b1;
        state_d   = ST_READ;
      end
      ST_READ: begin
        mem_cs    = 1'b1;
        lfsr_step = 1'b1;
        if (&addr_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // the access already on the bus completes; only the next state is overridden
    if (abort_hit) state_d = ST_IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q          <= '0;
      cmp_addr_q      <= '0;
      exp_q           <= '0;
      cmp_v_q         <= 1'b0;
      FAIL_CNT        <= '0;
      FIRST_FAIL_ADDR <= '0;
      PASS            <= 1'b0;
    end else if (abort_hit) begin
      addr_q  <= '0;
      cmp_v_q <= 1'b0;
      PASS    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START && !ABORT) begin
            addr_q          <= '0;
            FAIL_CNT        <= '0;
            FIRST_FAIL_ADDR <= '0;
            PASS            <= 1'b0;
          end
        end
        ST_WRITE:  addr_q <= addr_q + ADDR_ONE;
        ST_RESEED: addr_q <= '0;
        ST_READ: begin
          exp_q      <= lfsr_out;
          cmp_v_q    <= 1'b1;
          cmp_addr_q <= addr_q;
          addr_q     <= addr_q + ADDR_ONE;
        end
        ST_DRAIN: cmp_v_q <= 1'b0;
        ST_FIN:   PASS <= (FAIL_CNT == '0);
        default: ;
      endcase
      if (miscmp) begin
        FAIL_CNT <= FAIL_CNT + CNT_ONE;
        if (FAIL_CNT == '0) FIRST_FAIL_ADDR <= cmp_addr_q;
      end
    end
  end

  assign BUSY          = (state_q != ST_IDLE);
  assign DONE          = (state_q == ST_FIN);
  assign mem.MEM_CS    = mem_cs;
  assign mem.MEM_WE    = mem_we;
  assign mem.MEM_ADDR  = mem_cs ? addr_q : '0;
  assign mem.MEM_WDATA = mem_we ? lfsr_out : '0;

endmodule

// File: tb/tb_lfsr_bist_sequencer.sv
// tb/tb_lfsr_bist_sequencer.sv - directed self-checking bench for lfsr_bist_sequencer
module tb_lfsr_bist_sequencer;

  logic       CLK;
  logic       RST;
  logic       START;
  logic       ABORT;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [4:0] FAIL_CNT;
  logic [3:0] FIRST_FAIL_ADDR;

  lfsr_bist_sequencer_if #(.ADDR_W(4), .DATA_W(16)) bus ();

  lfsr_bist_sequencer #(.ADDR_W(4), .DATA_W(16), .SEED(16'h8000)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .START           (START),
    .ABORT           (ABORT),
    .BUSY            (BUSY),
    .DONE            (DONE),
    .PASS            (PASS),
    .FAIL_CNT        (FAIL_CNT),
    .FIRST_FAIL_ADDR (FIRST_FAIL_ADDR),
    .mem             (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM model: 0 = ideal, 1 = bit0 stuck-at-1 at addr 5, 2 = read data inverted
  int          fault_mode;
  logic [15:0] mem_arr [16];

  initial bus.MEM_RDATA = 16'h0;

  always @(posedge CLK) begin
    if (bus.MEM_CS && bus.MEM_WE) mem_arr[bus.MEM_ADDR] <= bus.MEM_WDATA;
    if (bus.MEM_CS && !bus.MEM_WE) begin
      if (fault_mode == 1 && bus.MEM_ADDR == 4'd5)
        bus.MEM_RDATA <= mem_arr[bus.MEM_ADDR] | 16'h0001;
      else if (fault_mode == 2)
        bus.MEM_RDATA <= ~mem_arr[bus.MEM_ADDR];
      else
        bus.MEM_RDATA <= mem_arr[bus.MEM_ADDR];
    end
  end

  int n_tests;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [15:0] wd_log   [0:41];
  logic [3:0]  addr_log [0:41];
  logic        cs_log   [0:41];
  logic        we_log   [0:41];
  logic        busy_log [0:41];
  logic        done_log [0:41];
  logic        pass_log [0:41];
  logic [4:0]  fail_log [0:41];
  logic [3:0]  ffa_log  [0:41];
  int          done_cycle;
  int          done_count;

  // cycle 1 is the first cycle after the edge that samples START
  task automatic run_bist(input int abort_at, input int rep_a, input int rep_b);
    done_cycle = 0;
    done_count = 0;
    START = 1'b1;
    ABORT = 1'b0;
    tick();
    START = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      wd_log[c]   = bus.MEM_WDATA;
      addr_log[c] = bus.MEM_ADDR;
      cs_log[c]   = bus.MEM_CS;
      we_log[c]   = bus.MEM_WE;
      busy_log[c] = BUSY;
      done_log[c] = DONE;
      pass_log[c] = PASS;
      fail_log[c] = FAIL_CNT;
      ffa_log[c]  = FIRST_FAIL_ADDR;
      if (DONE) begin
        done_count++;
        if (done_cycle == 0) done_cycle = c;
      end
      START = (c == rep_a) || (c == rep_b);
      ABORT = (c == abort_at);
      tick();
    end
    START = 1'b0;
    ABORT = 1'b0;
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [15:0] exp_pat [6];
  logic [15:0] seq;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    fault_mode = 0;
    START      = 1'b0;
    ABORT      = 1'b0;
    RST        = 1'b1;
    exp_pat[0] = 16'h8000;
    exp_pat[1] = 16'h0001;
    exp_pat[2] = 16'h0002;
    exp_pat[3] = 16'h0004;
    exp_pat[4] = 16'h0008;
    exp_pat[5] = 16'h0010;
    tick();
    tick();
    RST = 1'b0;
    tick();

    check_eq("rst_busy", {31'd0, BUSY}, 32'd0);
    check_eq("rst_done", {31'd0, DONE}, 32'd0);
    check_eq("rst_pass", {31'd0, PASS}, 32'd0);
    check_eq("rst_fail_cnt", {27'd0, FAIL_CNT}, 32'd0);
    check_eq("rst_cs", {31'd0, bus.MEM_CS}, 32'd0);
    check_eq("rst_wdata", {16'd0, bus.MEM_WDATA}, 32'd0);

    // clean memory
    run_bist(0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("clean_wdata%0d", i), {16'd0, wd_log[i+1]}, {16'd0, exp_pat[i]});
      check_eq($sformatf("clean_waddr%0d", i), {28'd0, addr_log[i+1]}, i);
    end
    check_eq("clean_we_c1", {31'd0, we_log[1]}, 32'd1);
    check_eq("clean_cs_c1", {31'd0, cs_log[1]}, 32'd1);
    check_eq("clean_cs_reseed", {31'd0, cs_log[17]}, 32'd0);
    check_eq("clean_cs_read", {31'd0, cs_log[18]}, 32'd1);
    check_eq("clean_we_read", {31'd0, we_log[18]}, 32'd0);
    check_eq("clean_raddr_c18", {28'd0, addr_log[18]}, 32'd0);
    check_eq("clean_cs_drain", {31'd0, cs_log[34]}, 32'd0);
    check_eq("clean_done_cycle", done_cycle, 35);
    check_eq("clean_done_count", done_count, 1);
    check_eq("clean_busy_c35", {31'd0, busy_log[35]}, 32'd1);
    check_eq("clean_busy_c36", {31'd0, busy_log[36]}, 32'd0);
    check_eq("clean_pass", {31'd0, pass_log[36]}, 32'd1);
    check_eq("clean_fail_cnt", {27'd0, fail_log[36]}, 32'd0);
    seq = 16'h8000;
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("clean_mem%0d", i), {16'd0, mem_arr[i]}, {16'd0, seq});
      seq = model_step(seq);
    end

    // bit0 stuck-at-1 at address 5
    fault_mode = 1;
    run_bist(0, 0, 0);
    check_eq("stuck_done_cycle", done_cycle, 35);
    check_eq("stuck_pass_at_done", {31'd0, pass_log[35]}, 32'd0);
    check_eq("stuck_fail_cnt", {27'd0, fail_log[35]}, 32'd1);
    check_eq("stuck_first_addr", {28'd0, ffa_log[35]}, 32'd5);
    check_eq("stuck_pass", {31'd0, pass_log[36]}, 32'd0);

    // every read inverted
    fault_mode = 2;
    run_bist(0, 0, 0);
    check_eq("inv_done_cycle", done_cycle, 35);
    check_eq("inv_fail_cnt", {27'd0, fail_log[36]}, 32'd16);
    check_eq("inv_first_addr", {28'd0, ffa_log[36]}, 32'd0);
    check_eq("inv_pass", {31'd0, pass_log[36]}, 32'd0);

    // abort during WRITE at addr 4, then a full clean run
    fault_mode = 0;
    run_bist(5, 0, 0);
    check_eq("abort_addr_c5", {28'd0, addr_log[5]}, 32'd4);
    check_eq("abort_cs_c5", {31'd0, cs_log[5]}, 32'd1);
    check_eq("abort_cs_c6", {31'd0, cs_log[6]}, 32'd0);
    check_eq("abort_busy_c6", {31'd0, busy_log[6]}, 32'd0);
    check_eq("abort_done_count", done_count, 0);
    check_eq("abort_pass", {31'd0, pass_log[6]}, 32'd0);
    run_bist(0, 0, 0);
    check_eq("after_abort_done_cycle", done_cycle, 35);
    check_eq("after_abort_pass", {31'd0, pass_log[36]}, 32'd1);

    // START re-pulsed while busy
    run_bist(0, 10, 35);
    check_eq("repulse_done_cycle", done_cycle, 35);
    check_eq("repulse_done_count", done_count, 1);
    check_eq("repulse_busy_c36", {31'd0, busy_log[36]}, 32'd0);
    check_eq("repulse_busy_c38", {31'd0, busy_log[38]}, 32'd0);

    // asynchronous reset in cycle 20 (READ) with failing reads
    fault_mode = 2;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    check_eq("rstmid_busy_before", {31'd0, BUSY}, 32'd1);
    check_eq("rstmid_fail_before", {27'd0, FAIL_CNT}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check_eq("rstmid_cs", {31'd0, bus.MEM_CS}, 32'd0);
    check_eq("rstmid_busy", {31'd0, BUSY}, 32'd0);
    check_eq("rstmid_done", {31'd0, DONE}, 32'd0);
    check_eq("rstmid_pass", {31'd0, PASS}, 32'd0);
    check_eq("rstmid_fail_cnt", {27'd0, FAIL_CNT}, 32'd0);
    tick();
    RST = 1'b0;
    tick();
    tick();
    check_eq("rstmid_idle_busy", {31'd0, BUSY}, 32'd0);
    check_eq("rstmid_idle_cs", {31'd0, bus.MEM_CS}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
